// File: rtl/bsa_pkg.sv
// Shared types and helpers for the byte-serial adder.
package bsa_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n)), 0 for n <= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // byte index width; never zero so NBYTES=1 still gets a real register
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/prefix_add8_co.sv
// Combinational 8-bit Kogge-Stone adder. Also exposes the carry into bit 7
// so the caller can form signed overflow on the top byte.
module prefix_add8_co
  import bsa_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              c7,
  output logic              cout
);

  logic [BYTE_W-1:0] p0;
  logic [BYTE_W-1:0] g, pp, gn, pn;

  assign p0 = a ^ b;

  // Prefix tree: cin folded into bit 0's generate, then log2(8) levels at
  // distance 1, 2, 4. g[i] ends up as the carry out of bit i.
  always_comb begin
    g    = a & b;
    g[0] = g[0] | (p0[0] & cin);
    pp   = p0;
    gn   = '0;
    pn   = '0;
    for (int d = 1; d < BYTE_W; d = d * 2) begin
      gn = g;
      pn = pp;
      for (int i = d; i < BYTE_W; i++) begin
        gn[i] = g[i] | (pp[i] & g[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      g  = gn;
      pp = pn;
    end
  end

  assign sum  = p0 ^ {g[BYTE_W-2:0], cin};
  assign c7   = g[BYTE_W-2];
  assign cout = g[BYTE_W-1];

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder built from one 8-bit slice, one byte per clock, LSB first.
// Operands shift right so byte 0 of each is always at the slice input.
module byte_serial_adder
  import bsa_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = idx_w(NBYTES);

  state_t            state, state_nxt;
  logic [W-1:0]      a_sh, b_sh, sum_q;
  logic              carry, cout_q, ovf_q;
  logic [IW-1:0]     idx;
  logic              last;

  logic [BYTE_W-1:0] s_sum;
  logic              s_c7, s_cout;

  assign last = (idx == IW'(NBYTES - 1));

  prefix_add8_co u_slice (
    .a    (a_sh[BYTE_W-1:0]),
    .b    (b_sh[BYTE_W-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .c7   (s_c7),
    .cout (s_cout)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: accept in IDLE, walk the bytes in RUN, hold in DONE until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs are pure state decodes, so no accept can overlap a handoff
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // datapath: capture, shift operands, place each result byte, latch flags on the last byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          idx   <= '0;
        end
        RUN: begin
          a_sh  <= a_sh >> BYTE_W;
          b_sh  <= b_sh >> BYTE_W;
          carry <= s_cout;
          idx   <= idx + 1'b1;
          for (int k = 0; k < NBYTES; k++) begin
            if (idx == IW'(k)) sum_q[k*BYTE_W +: BYTE_W] <= s_sum;
          end
          if (last) begin
            cout_q <= s_cout;
            ovf_q  <= s_c7 ^ s_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder at NBYTES=4.
module tb_byte_serial_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  byte_serial_adder #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Present operands, accept, then count edges (accepting edge is edge 1)
  // until out_valid. Inputs are scrambled after accept to prove capture.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [W-1:0] es,
                         input logic ec, input logic eo, input string tag);
    int edges;
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = ~tc;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'(NB + 1));
    chk({tag, "_sum"},  64'(sum),  64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"},  64'(ovf),  64'(eo));
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] held;

    // reset values while held in reset
    #3;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_cout",      64'(cout),      64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready while idle does nothing
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_ordy_ov", 64'(out_valid), 64'd0);

    run_add(32'h0000000A, 32'h00000014, 1'b0, 32'h0000001E, 1'b0, 1'b0, "t1");
    handoff("t1");
    run_add(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, "t2");
    handoff("t2");
    run_add(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, "t3");
    handoff("t3");
    run_add(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "t4");
    handoff("t4");
    run_add(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, "neg_ovf");
    handoff("neg_ovf");
    run_add(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, "m1m1");
    handoff("m1m1");

    // hold the result for 10 cycles while poking the input side
    run_add(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, "t5");
    held = 32'h23456789;
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid;
      a = a ^ 32'hA5A5A5A5;
      b = 32'h00000001;
      @(posedge clk); #1;
      chk("t5_hold_sum", 64'(sum), 64'(held));
      chk("t5_hold_rdy", 64'(in_ready), 64'd0);
      chk("t5_hold_ov",  64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    handoff("t5");

    // reset two cycles into RUN
    a = 32'h55555555; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy",  64'(in_ready),  64'd1);
    chk("t6_rst_ov",   64'(out_valid), 64'd0);
    chk("t6_rst_sum",  64'(sum),       64'd0);
    chk("t6_rst_cout", 64'(cout),      64'd0);
    chk("t6_rst_ovf",  64'(ovf),       64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle_ov", 64'(out_valid), 64'd0);
    run_add(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, "t6");
    handoff("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
